ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit with an internal instruction memory, a prefetch FIFO and a valid/ready output to decode. It fetches sequentially from a PC and buffers up to FIFO_DEPTH instruction/PC pairs. Decode drains the buffer under backpressure. A redirect input flushes the buffer and restarts fetch from a new PC, for use by branches and jumps from later stages.

---
 rtl/ifu_pkg.sv | 29 ++
 rtl/ifu_fifo.sv | 58 +++++
 rtl/ifu_prefetch.sv | 116 +++++++++++
 tb/tb_ifu_prefetch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
`default_nettype none
// ==========================================================================
// ifu_pkg : shared types and default constants for the instruction fetch unit
// Rev 1.0 : initial release
// ==========================================================================
package ifu_pkg;

  localparam int DEF_INSTR_W    = 16;
  localparam int DEF_PC_W       = 16;
  localparam int DEF_IMEM_AW    = 10;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_RESET_PC   = 0;

  typedef enum logic [0:0] {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_INSTR_W-1:0] instr;
  } ifu_entry_t;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// ==========================================================================
// ifu_fifo : synchronous FIFO with flush, occupancy count, combinational head
// Rev 1.0 : initial release
// ==========================================================================
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = count_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CW-1:0]     count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [CW-1:0]     count_q;

  // Flush wins over push and pop; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) begin
        rd_q <= rd_q + 1'b1;
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ==========================================================================
// ifu_prefetch : sequential instruction prefetch with redirect and decode handshake
// Rev 1.0 : initial release
// ==========================================================================
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int PC_W       = DEF_PC_W,
  parameter int IMEM_AW    = DEF_IMEM_AW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
  localparam int CW        = count_width(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    fetch_pc,
  output logic [CW-1:0]      fifo_count,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata
);

  ifu_state_e         state_q;
  logic [PC_W-1:0]    fetch_pc_q;
  logic               inflight_q;
  logic [PC_W-1:0]    inflight_pc_q;
  logic [INSTR_W-1:0] rdata_q;
  logic [INSTR_W-1:0] imem [2**IMEM_AW];

  logic               fetch_go;
  logic               pop;
  logic               push;
  logic               issue;
  logic [CW:0]        occupancy;
  logic [PC_W+INSTR_W-1:0] head;

  // HALT issues on the same edge it leaves for RUN, giving a two-edge first-valid latency.
  always_comb begin
    fetch_go = 1'b0;
    case (state_q)
      ST_HALT: fetch_go = en;
      ST_RUN:  fetch_go = en;
      default: fetch_go = 1'b0;
    endcase
  end

  assign pop       = out_valid & out_ready;
  assign push      = inflight_q & ~redirect_valid;
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign issue     = fetch_go & ~redirect_valid & (occupancy < (CW+1)'(FIFO_DEPTH));

  // Read-first memory: a same-edge write to the fetched word is seen by later fetches only.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
    if (issue) begin
      rdata_q <= imem[fetch_pc_q[IMEM_AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_HALT;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      case (state_q)
        ST_HALT: if (en)  state_q <= ST_RUN;
        ST_RUN:  if (!en) state_q <= ST_HALT;
        default: state_q <= ST_HALT;
      endcase
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        inflight_q <= 1'b0;
      end else begin
        inflight_q <= issue;
        if (issue) begin
          inflight_pc_q <= fetch_pc_q;
          fetch_pc_q    <= fetch_pc_q + 1'b1;
        end
      end
    end
  end

  ifu_fifo #(
    .DATA_W (PC_W + INSTR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  ({inflight_pc_q, rdata_q}),
    .pop_i   (pop & ~redirect_valid),
    .head_o  (head),
    .count_o (fifo_count)
  );

  assign out_valid = |fifo_count;
  assign out_pc    = head[PC_W+INSTR_W-1:INSTR_W];
  assign out_instr = head[INSTR_W-1:0];
  assign fetch_pc  = fetch_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ==========================================================================
// tb_ifu_prefetch : directed and random checks of ifu_prefetch against a queue model
// Rev 1.0 : initial release
// ==========================================================================
module tb_ifu_prefetch;
  import ifu_pkg::*;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] fetch_pc;
  logic [2:0]  fifo_count;
  logic        imem_we;
  logic [9:0]  imem_waddr;
  logic [15:0] imem_wdata;

  always #5 clk = ~clk;

  ifu_prefetch dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_pc       (fetch_pc),
    .fifo_count     (fifo_count),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: memory image, queue of buffered {pc,instr}, one optional outstanding fetch.
  logic [15:0] mem_m [1024];
  ifu_entry_t  q [$];
  logic [15:0] m_fpc;
  bit          m_infl;
  ifu_entry_t  m_infl_e;

  task automatic model_reset();
    q.delete();
    m_infl = 1'b0;
    m_fpc  = 16'h0000;
  endtask

  task automatic model_edge();
    bit pop;
    int occ;
    pop = (q.size() != 0) && out_ready;
    if (redirect_valid) begin
      q.delete();
      m_infl = 1'b0;
      m_fpc  = redirect_pc;
    end else begin
      occ = q.size() + int'(m_infl) - int'(pop);
      if (pop) void'(q.pop_front());
      if (m_infl) q.push_back(m_infl_e);
      if (en && occ < D) begin
        m_infl_e.pc    = m_fpc;
        m_infl_e.instr = mem_m[m_fpc[9:0]];
        m_infl         = 1'b1;
        m_fpc          = m_fpc + 16'd1;
      end else begin
        m_infl = 1'b0;
      end
    end
    if (imem_we) mem_m[imem_waddr] = imem_wdata;
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("fetch_pc", 32'(fetch_pc), 32'(m_fpc));
    if (q.size() != 0) begin
      check("out_pc", 32'(out_pc), 32'(q[0].pc));
      check("out_instr", 32'(out_instr), 32'(q[0].instr));
    end
  endtask

  task automatic step();
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic redirect_to(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    model_reset();

    // Memory loads proceed while reset is held.
    for (int a = 0; a < 1024; a++) begin
      imem_we    = 1'b1;
      imem_waddr = 10'(a);
      if (a < 6)            imem_wdata = 16'h1000 + 16'(a);
      else if (a == 'h200)  imem_wdata = 16'hBEEF;
      else                  imem_wdata = 16'($urandom);
      mem_m[a] = imem_wdata;
      @(posedge clk); #1;
    end
    imem_we = 1'b0;

    check("rst_valid", 32'(out_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_fetch_pc", 32'(fetch_pc), 0);
    check("rst_out_instr", 32'(out_instr), 0);
    check("rst_out_pc", 32'(out_pc), 0);

    // Streaming from reset: first valid two edges after release, then one per cycle.
    reset = 1'b1; en = 1'b1; out_ready = 1'b1;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      check("stream_valid", 32'(out_valid), 1);
      check("stream_pc", 32'(out_pc), i);
      check("stream_instr", 32'(out_instr), 32'h1000 + i);
      step();
    end

    // Backpressure saturates the buffer, then drains in order.
    redirect_to(16'h0000);
    out_ready = 1'b0;
    repeat (8) step();
    check("sat_count", 32'(fifo_count), 4);
    check("sat_fetch_pc", 32'(fetch_pc), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("drain_pc", 32'(out_pc), i);
      check("drain_instr", 32'(out_instr), 32'h1000 + i);
      step();
    end

    // Redirect with three buffered entries and one read outstanding.
    out_ready = 1'b0;
    redirect_to(16'h0010);
    repeat (4) step();
    check("pre_redir_count", 32'(fifo_count), 3);
    redirect_to(16'h0200);
    check("redir_valid", 32'(out_valid), 0);
    check("redir_count", 32'(fifo_count), 0);
    step();
    check("redir_gap_valid", 32'(out_valid), 0);
    step();
    check("redir_head_valid", 32'(out_valid), 1);
    check("redir_head_pc", 32'(out_pc), 32'h0200);
    check("redir_head_instr", 32'(out_instr), 32'hBEEF);

    // Memory index aliasing and PC wrap.
    out_ready = 1'b1;
    redirect_to(16'h03FF);
    step(); step();
    check("wrap_pc_3ff", 32'(out_pc), 32'h03FF);
    step();
    check("wrap_pc_400", 32'(out_pc), 32'h0400);
    check("wrap_instr_alias", 32'(out_instr), 32'h1000);
    redirect_to(16'hFFFF);
    check("wrap_fetch_ffff", 32'(fetch_pc), 32'hFFFF);
    step();
    check("wrap_fetch_0", 32'(fetch_pc), 0);

    // Dropping en: the outstanding read lands, nothing further issues.
    out_ready = 1'b0;
    redirect_to(16'h0020);
    step();
    en = 1'b0;
    step();
    check("en_off_count", 32'(fifo_count), 1);
    check("en_off_fetch_pc", 32'(fetch_pc), 32'h0021);
    repeat (3) step();
    check("en_off_count_hold", 32'(fifo_count), 1);
    check("en_off_fetch_hold", 32'(fetch_pc), 32'h0021);
    en = 1'b1;
    step(); step();
    check("en_on_count", 32'(fifo_count), 2);
    check("en_on_fetch_pc", 32'(fetch_pc), 32'h0023);

    // Randomised traffic, redirects and memory writes against the model.
    for (int n = 0; n < 3000; n++) begin
      en             = ($urandom_range(0, 9) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 16'h03FE;
        1:       redirect_pc = 16'hFFFE;
        default: redirect_pc = 16'($urandom);
      endcase
      imem_we    = ($urandom_range(0, 7) == 0);
      imem_waddr = (imem_we && $urandom_range(0, 1) == 0) ? m_fpc[9:0] : 10'($urandom);
      imem_wdata = 16'($urandom);
      step();
    end
    redirect_valid = 1'b0; imem_we = 1'b0;

    // Asynchronous reset between edges while streaming.
    en = 1'b1; out_ready = 1'b1;
    repeat (5) step();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_count", 32'(fifo_count), 0);
    check("async_rst_fetch_pc", 32'(fetch_pc), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    step(); step();
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_pc", 32'(out_pc), 0);
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
